// File: rtl/prbs_gen_param.sv
// ---------------------------------------------------------------------------
// prbs_gen_param
// Parameterised PRBS word generator with selectable polynomial
// (PRBS7/9/15/23/31).
//
// Each generated word holds WIDTH consecutive LFSR output bits.
// dout[0] is the oldest bit of the word.
// Words are handed out through a valid/ready pair.
// A single-word error injection is available, and the block keeps a
// running count of accepted words.
//
// Parameters
//   WIDTH      output bits per word (1..32)
//   DEF_MODE   polynomial selected out of reset
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous active-low reset
//   load        load seed/mode, flush output word (highest priority)
//   mode        polynomial select: 0=PRBS7 1=PRBS9 2=PRBS15 3=PRBS23
//               4=PRBS31, 5..7 behave as 4
//   seed        initial LFSR state (masked to the active length)
//   en          permits generation of new words
//   err_inj     invert dout[0] of the next generated word
//   dout        generated word
//   dout_valid  dout holds an unconsumed word
//   dout_ready  consumer accepts dout
//   word_cnt    number of accepted words (wraps)
// ---------------------------------------------------------------------------
module prbs_gen_param #(
    parameter int         WIDTH    = 8,
    parameter logic [2:0] DEF_MODE = 3'd0
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [2:0]       mode,
    input  logic [30:0]      seed,
    input  logic             en,
    input  logic             err_inj,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic [31:0]      word_cnt
);

    // Fold the reserved mode codes onto PRBS31.
    function automatic logic [2:0] map_mode(input logic [2:0] m);
        logic [2:0] r;
        if (m > 3'd4) begin
            r = 3'd4;
        end else begin
            r = m;
        end
        return r;
    endfunction

    // All-ones mask over the active LFSR length of a (mapped) mode.
    function automatic logic [30:0] mode_mask(input logic [2:0] m);
        logic [30:0] r;
        case (m)
            3'd0:    r = 31'h0000_007F;
            3'd1:    r = 31'h0000_01FF;
            3'd2:    r = 31'h0000_7FFF;
            3'd3:    r = 31'h007F_FFFF;
            default: r = 31'h7FFF_FFFF;
        endcase
        return r;
    endfunction

    // Bit index N-1 (the x^N term) for a mapped mode.
    function automatic logic [4:0] tap_hi(input logic [2:0] m);
        logic [4:0] r;
        case (m)
            3'd0:    r = 5'd6;
            3'd1:    r = 5'd8;
            3'd2:    r = 5'd14;
            3'd3:    r = 5'd22;
            default: r = 5'd30;
        endcase
        return r;
    endfunction

    // Bit index T-1 (the x^T term) for a mapped mode.
    function automatic logic [4:0] tap_lo(input logic [2:0] m);
        logic [4:0] r;
        case (m)
            3'd0:    r = 5'd5;
            3'd1:    r = 5'd4;
            3'd2:    r = 5'd13;
            3'd3:    r = 5'd17;
            default: r = 5'd27;
        endcase
        return r;
    endfunction

    localparam logic [2:0]  RST_MODE  = map_mode(DEF_MODE);
    localparam logic [30:0] RST_STATE = mode_mask(RST_MODE);

    logic [30:0]      state_r;
    logic [2:0]       mode_r;
    logic [WIDTH-1:0] dout_r;
    logic             dout_valid_r;
    logic [31:0]      word_cnt_r;

    logic [30:0]      step_state_s;
    logic [WIDTH-1:0] word_s;
    logic [WIDTH-1:0] word_out_s;
    logic [30:0]      cur_mask_s;
    logic [4:0]       cur_hi_s;
    logic [4:0]       cur_lo_s;
    logic [2:0]       new_mode_s;
    logic [30:0]      new_mask_s;
    logic [30:0]      seed_masked_s;
    logic [30:0]      load_state_s;
    logic             gen_s;
    logic             accept_s;

    // Decode taps and mask of the active polynomial.
    always_comb begin
        cur_mask_s = mode_mask(mode_r);
        cur_hi_s   = tap_hi(mode_r);
        cur_lo_s   = tap_lo(mode_r);
    end

    // Run WIDTH LFSR steps; bit i of the word is the feedback of step i.
    always_comb begin : step_blk
        logic fb_v;
        fb_v         = 1'b0;
        step_state_s = state_r;
        word_s       = '0;
        for (int i = 0; i < WIDTH; i++) begin
            fb_v         = step_state_s[cur_hi_s] ^ step_state_s[cur_lo_s];
            word_s[i]    = fb_v;
            // Masking keeps bits above the active length at zero.
            step_state_s = {step_state_s[29:0], fb_v} & cur_mask_s;
        end
        word_out_s    = word_s;
        word_out_s[0] = word_s[0] ^ err_inj;
    end

    // Seed preparation for a load, including the all-zero guard.
    always_comb begin
        new_mode_s    = map_mode(mode);
        new_mask_s    = mode_mask(new_mode_s);
        seed_masked_s = seed & new_mask_s;
        if (seed_masked_s == 31'h0000_0000) begin
            load_state_s = new_mask_s;
        end else begin
            load_state_s = seed_masked_s;
        end
    end

    // Handshake decode: a word is produced when the output slot is free or
    // being drained this cycle; a load suppresses generation.
    always_comb begin
        gen_s    = en && (!dout_valid_r || dout_ready) && !load;
        accept_s = dout_valid_r && dout_ready;
    end

    // LFSR state, mode register and output word/valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= RST_STATE;
            mode_r       <= RST_MODE;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else if (load) begin
            state_r      <= load_state_s;
            mode_r       <= new_mode_s;
            dout_r       <= '0;
            dout_valid_r <= 1'b0;
        end else if (gen_s) begin
            state_r      <= step_state_s;
            dout_r       <= word_out_s;
            dout_valid_r <= 1'b1;
        end else if (accept_s) begin
            dout_valid_r <= 1'b0;
        end else begin
            dout_valid_r <= dout_valid_r;
        end
    end

    // Accepted-word counter; counts on load cycles too and never clears on load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            word_cnt_r <= 32'h0000_0000;
        end else if (accept_s) begin
            word_cnt_r <= word_cnt_r + 32'h0000_0001;
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    assign dout       = dout_r;
    assign dout_valid = dout_valid_r;
    assign word_cnt   = word_cnt_r;

endmodule

// File: doc/prbs_gen_param.md
PRBS_GEN_PARAM -- requirements
Module: prbs_gen_param

Interface
REQ-001 Parameter WIDTH, default 8, output bits per word; legal range 1..32.
REQ-002 Parameter DEF_MODE, default 3'd0, mode register value after reset.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset, asynchronous, active-low.
REQ-005 load  input  1  loads seed and mode, and flushes the output word.
REQ-006 mode  input  3  polynomial select, sampled only when load=1: 0=PRBS7 x^7+x^6+1, 1=PRBS9 x^9+x^5+1, 2=PRBS15 x^15+x^14+1, 3=PRBS23 x^23+x^18+1, 4=PRBS31 x^31+x^28+1; 5..7 treated as 4.
REQ-007 seed  input  31  initial LFSR state, sampled only when load=1.
REQ-008 en  input  1  permits generation of new words.
REQ-009 err_inj  input  1  flips dout[0] of the next generated word.
REQ-010 dout  output  WIDTH  generated word; dout[0] is the oldest bit.
REQ-011 dout_valid  output  1  dout holds an unconsumed word.
REQ-012 dout_ready  input  1  consumer accepts dout when dout_valid=1.
REQ-013 word_cnt  output  32  count of accepted words (dout_valid & dout_ready).

Function
REQ-014 Internal state: 31-bit LFSR register S (only the low N bits are active; N=7/9/15/23/31 per mode) and a 3-bit mode register.
REQ-015 One LFSR step for polynomial x^N+x^T+1: fb = S[N-1]^S[T-1]; S[N-1:0] <= {S[N-2:0], fb}; S[30:N] stays 0; the output bit is fb.
REQ-016 One word = WIDTH consecutive steps in one cycle; bit i of the word is the fb of step i; S advances by WIDTH steps.
REQ-017 Generate condition: en=1 and (dout_valid=0 or dout_ready=1) and load=0. On this condition dout <= word, S advances, and dout_valid <= 1.
REQ-018 Consume without generate (dout_valid=1, dout_ready=1, en=0): dout_valid <= 0; dout and S hold.
REQ-019 Stall (dout_valid=1, dout_ready=0): dout, dout_valid and S hold; changes to en and err_inj have no effect.
REQ-020 load=1 has priority over everything else: S <= seed masked to N bits of the new mode; mode register <= mode (mapped per REQ-006); dout_valid <= 0; dout <= 0; no word is generated that cycle.
REQ-021 Zero-seed guard: if the masked seed is all zeros, S <= all-ones over N bits.
REQ-022 Latency: load at edge k, en=1 and dout_ready=1 from then on gives first dout_valid=1 after edge k+1, then a new word every cycle.
REQ-023 err_inj is honoured only on a generate cycle: the registered dout[0] is inverted; S is unaffected; err_inj outside a generate cycle is dropped.
REQ-024 word_cnt increments by 1 on each cycle with dout_valid & dout_ready, including load cycles; it wraps from 0xFFFFFFFF to 0; load does not clear it.
REQ-025 The sequence period is 2^N-1 steps for every mode and never enters the all-zero state.

Reset
REQ-026 On rst_n=0, asynchronously: S <= all-ones over N bits of DEF_MODE; mode register <= DEF_MODE; dout <= 0; dout_valid <= 0; word_cnt <= 0.
REQ-027 Reset asserted mid-stall discards the pending word; after release the first word is the seed-all-ones sequence from its start.
REQ-028 rst_n release is synchronous to clk externally; no output changes on the release edge except through REQ-017.

Verification
REQ-029 WIDTH=1, load mode=0 seed=7'h7F, en=1, ready=1 -> first 7 dout bits are 0,0,0,0,0,0,1; the bit stream repeats exactly after 127 words.
REQ-030 WIDTH=8, mode=0 seed=0 -> same stream as seed 7'h7F; the 8-bit words equal consecutive 8-bit groups of the WIDTH=1 stream, LSB first.
REQ-031 Ready held 0 for 5 cycles with valid=1 -> dout is stable for 5 cycles and word_cnt is unchanged; after ready returns, no bits are skipped or repeated.
REQ-032 err_inj pulse on a generate cycle -> exactly that word differs from the golden word in bit 0 only, and the following words match the golden model.
REQ-033 For each mode 0..4 (WIDTH=1) -> period measured equals 2^N-1 (127, 511, 32767, 2^23-1, 2^31-1 checked by a reference model over 10^6 bits for N>=23), and mode=6 behaves as mode=4.
REQ-034 load asserted while dout_valid=1, dout_ready=0 -> dout_valid=0 next cycle; the first subsequent word comes from the new seed; rst_n pulse mid-stream -> outputs reset immediately without waiting for a clk edge.
